// File: rtl/lockstep_stutter_ctrl_if.sv
// Retire/observation bundle between the two DarkRISCV copies and the stutter scheduler.
// The harness side is the master; the scheduler is the slave.
interface lockstep_stutter_ctrl_if #(
  parameter int OBS_W = 32,
  parameter int CNT_W = 16
);
  logic             ret_vld_l;
  logic [OBS_W-1:0] ret_obs_l;
  logic             ret_vld_r;
  logic [OBS_W-1:0] ret_obs_r;
  logic             stall_l;
  logic             stall_r;
  logic             pair_vld;
  logic             src_cand_equiv;
  logic             stutter_to;
  logic             proto_err;
  logic [CNT_W-1:0] pair_cnt;

  modport master (
    output ret_vld_l, ret_obs_l, ret_vld_r, ret_obs_r,
    input  stall_l, stall_r, pair_vld, src_cand_equiv, stutter_to, proto_err, pair_cnt
  );

  modport slave (
    input  ret_vld_l, ret_obs_l, ret_vld_r, ret_obs_r,
    output stall_l, stall_r, pair_vld, src_cand_equiv, stutter_to, proto_err, pair_cnt
  );
endinterface

// File: rtl/lockstep_stutter_ctrl.sv
// Stutter scheduler: stalls the leading copy until its partner retires, then
// compares the paired observations; divergence, timeout and protocol errors are sticky.
module lockstep_stutter_ctrl #(
  parameter int OBS_W       = 32,
  parameter int MAX_STUTTER = 16,
  parameter int CNT_W       = 16
) (
  input  logic                   XCLK,
  input  logic                   XRES,
  lockstep_stutter_ctrl_if.slave bus
);
  localparam int WCNT_W = (MAX_STUTTER > 1) ? $clog2(MAX_STUTTER) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MAX_STUTTER - 1);

  typedef enum logic [2:0] {RUN, WAIT_R, WAIT_L, FAIL, TIMEOUT} state_e;

  state_e            state_q;
  logic [OBS_W-1:0]  hold_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic              pair_vld_q, equiv_q, stutter_to_q, proto_err_q;
  logic [CNT_W-1:0]  pair_cnt_q, pair_cnt_d;
  logic              cmp_vld, cmp_mis;
  logic [OBS_W-1:0]  cmp_a, cmp_b;

  // One comparator serves all states: RUN pairs the live strobes, WAIT_x pairs hold with the partner.
  always_comb begin
    cmp_vld = 1'b0;
    cmp_a   = hold_q;
    cmp_b   = bus.ret_obs_r;
    case (state_q)
      RUN: begin
        cmp_vld = bus.ret_vld_l & bus.ret_vld_r;
        cmp_a   = bus.ret_obs_l;
      end
      WAIT_R: cmp_vld = bus.ret_vld_r;
      WAIT_L: begin
        cmp_vld = bus.ret_vld_l;
        cmp_b   = bus.ret_obs_l;
      end
      default: ;
    endcase
  end

  assign cmp_mis    = (cmp_a != cmp_b);
  assign pair_cnt_d = (&pair_cnt_q) ? pair_cnt_q : pair_cnt_q + CNT_W'(1);

  always_ff @(posedge XCLK) begin
    if (!XRES) begin
      state_q      <= RUN;
      hold_q       <= '0;
      wcnt_q       <= '0;
      pair_vld_q   <= 1'b0;
      pair_cnt_q   <= '0;
      equiv_q      <= 1'b1;
      stutter_to_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      pair_vld_q <= cmp_vld;
      if (cmp_vld) begin
        pair_cnt_q <= pair_cnt_d;
        if (cmp_mis) equiv_q <= 1'b0;
      end
      case (state_q)
        RUN: begin
          if (bus.ret_vld_l && bus.ret_vld_r) begin
            if (cmp_mis) state_q <= FAIL;
          end else if (bus.ret_vld_l) begin
            hold_q  <= bus.ret_obs_l;
            wcnt_q  <= '0;
            state_q <= WAIT_R;
          end else if (bus.ret_vld_r) begin
            hold_q  <= bus.ret_obs_r;
            wcnt_q  <= '0;
            state_q <= WAIT_L;
          end
        end
        WAIT_R, WAIT_L: begin
          // The stalled copy's strobe is a violation; its observation is dropped.
          if ((state_q == WAIT_R) ? bus.ret_vld_l : bus.ret_vld_r) begin
            proto_err_q <= 1'b1;
            equiv_q     <= 1'b0;
          end
          if (cmp_vld) begin
            state_q <= cmp_mis ? FAIL : RUN;
          end else if (wcnt_q == WCNT_LAST) begin
            state_q      <= TIMEOUT;
            stutter_to_q <= 1'b1;
            equiv_q      <= 1'b0;
          end else begin
            wcnt_q <= wcnt_q + WCNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stall_l        = (state_q == WAIT_R) || (state_q == FAIL) || (state_q == TIMEOUT);
  assign bus.stall_r        = (state_q == WAIT_L) || (state_q == FAIL) || (state_q == TIMEOUT);
  assign bus.pair_vld       = pair_vld_q;
  assign bus.pair_cnt       = pair_cnt_q;
  assign bus.src_cand_equiv = equiv_q;
  assign bus.stutter_to     = stutter_to_q;
  assign bus.proto_err      = proto_err_q;
endmodule

// File: tb/tb_lockstep_stutter_ctrl.sv
// Scenario bench for lockstep_stutter_ctrl: expected pairs queued at stimulus time,
// popped when pair_vld appears exactly one cycle later.
module tb_lockstep_stutter_ctrl;
  localparam int OBS_W = 32;
  localparam int CNT_W = 3;
  localparam int MAXS  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lockstep_stutter_ctrl_if #(.OBS_W(OBS_W), .CNT_W(CNT_W)) bus ();

  lockstep_stutter_ctrl #(.OBS_W(OBS_W), .MAX_STUTTER(MAXS), .CNT_W(CNT_W)) dut (
    .XCLK (clk),
    .XRES (rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [CNT_W-1:0] cnt;
    logic             equiv;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               failures = 0;
  logic [CNT_W-1:0] model_cnt;
  logic             model_equiv;

  function automatic void push_pair(input bit mis);
    if (!(&model_cnt)) model_cnt = model_cnt + 1'b1;
    if (mis) model_equiv = 1'b0;
    sb.push_back('{model_cnt, model_equiv});
  endfunction

  // Advance one cycle and settle the scoreboard against the post-edge outputs.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.pair_vld === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pair_vld t=%0t got pair_vld=1 want 0", $time);
      end else begin
        e = sb.pop_front();
        if (bus.pair_cnt !== e.cnt || bus.src_cand_equiv !== e.equiv) begin
          failures++;
          $display("FAIL pair_result t=%0t got cnt=%0d equiv=%b want cnt=%0d equiv=%b",
                   $time, bus.pair_cnt, bus.src_cand_equiv, e.cnt, e.equiv);
        end
      end
    end else if (sb.size() != 0) begin
      checks++;
      failures++;
      e = sb.pop_front();
      $display("FAIL pair_missing t=%0t got pair_vld=%b want 1 (cnt=%0d)", $time, bus.pair_vld, e.cnt);
    end
  endtask

  task automatic drive(input bit vl, input logic [OBS_W-1:0] ol, input bit vr, input logic [OBS_W-1:0] orr);
    bus.ret_vld_l = vl;
    bus.ret_obs_l = ol;
    bus.ret_vld_r = vr;
    bus.ret_obs_r = orr;
  endtask

  task automatic do_reset();
    drive(0, '0, 0, '0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_cnt   = '0;
    model_equiv = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.stall_l, bus.stall_r, bus.pair_vld, bus.src_cand_equiv, bus.stutter_to, bus.proto_err} !== 6'b000100) begin
      failures++;
      $display("FAIL reset_flags got sl=%b sr=%b pv=%b eq=%b to=%b pe=%b want 0 0 0 1 0 0",
               bus.stall_l, bus.stall_r, bus.pair_vld, bus.src_cand_equiv, bus.stutter_to, bus.proto_err);
    end
    checks++;
    if (bus.pair_cnt !== '0) begin
      failures++;
      $display("FAIL reset_cnt got %0d want 0", bus.pair_cnt);
    end
  endtask

  task automatic test_lockstep();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h100 + 32'(4 * i), 1, 32'h100 + 32'(4 * i));
      push_pair(0);
      tick();
      checks++;
      if (bus.stall_l !== 1'b0 || bus.stall_r !== 1'b0) begin
        failures++;
        $display("FAIL lockstep_stall got %b%b want 00", bus.stall_l, bus.stall_r);
      end
    end
    drive(0, '0, 0, '0);
    tick();
    checks++;
    if (bus.pair_cnt !== 3'd3 || bus.src_cand_equiv !== 1'b1 || bus.pair_vld !== 1'b0) begin
      failures++;
      $display("FAIL lockstep_final got cnt=%0d eq=%b pv=%b want 3 1 0", bus.pair_cnt, bus.src_cand_equiv, bus.pair_vld);
    end
  endtask

  task automatic test_left_ahead();
    do_reset();
    drive(1, 32'h200, 0, '0);
    tick();
    drive(0, '0, 0, '0);
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (bus.stall_l !== 1'b1 || bus.stall_r !== 1'b0) begin
        failures++;
        $display("FAIL left_ahead_stall c=%0d got %b%b want 10", c, bus.stall_l, bus.stall_r);
      end
      if (c == 3) begin
        drive(0, '0, 1, 32'h200);
        push_pair(0);
      end
      tick();
    end
    drive(0, '0, 0, '0);
    checks++;
    if (bus.stall_l !== 1'b0 || bus.stall_r !== 1'b0 || bus.src_cand_equiv !== 1'b1) begin
      failures++;
      $display("FAIL left_ahead_done got sl=%b sr=%b eq=%b want 0 0 1", bus.stall_l, bus.stall_r, bus.src_cand_equiv);
    end
    drive(1, 32'h204, 1, 32'h204);
    push_pair(0);
    tick();
    drive(0, '0, 0, '0);
    tick();
  endtask

  task automatic test_mismatch();
    do_reset();
    drive(1, 32'h300, 1, 32'h304);
    push_pair(1);
    tick();
    checks++;
    if (bus.src_cand_equiv !== 1'b0 || bus.stall_l !== 1'b1 || bus.stall_r !== 1'b1) begin
      failures++;
      $display("FAIL mismatch_enter got eq=%b sl=%b sr=%b want 0 1 1", bus.src_cand_equiv, bus.stall_l, bus.stall_r);
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'($urandom), $urandom, 1'($urandom), $urandom);
      tick();
      checks++;
      if (bus.stall_l !== 1'b1 || bus.stall_r !== 1'b1 || bus.proto_err !== 1'b0 || bus.src_cand_equiv !== 1'b0) begin
        failures++;
        $display("FAIL mismatch_hold i=%0d got sl=%b sr=%b pe=%b eq=%b want 1 1 0 0",
                 i, bus.stall_l, bus.stall_r, bus.proto_err, bus.src_cand_equiv);
      end
    end
    drive(0, '0, 0, '0);
  endtask

  task automatic test_timeout(input bit partner);
    do_reset();
    drive(0, '0, 1, 32'hAB);
    tick();
    drive(0, '0, 0, '0);
    for (int c = 1; c <= MAXS; c++) begin
      checks++;
      if (bus.stall_r !== 1'b1 || bus.stall_l !== 1'b0 || bus.stutter_to !== 1'b0) begin
        failures++;
        $display("FAIL timeout_wait c=%0d got sr=%b sl=%b to=%b want 1 0 0", c, bus.stall_r, bus.stall_l, bus.stutter_to);
      end
      if (c == MAXS && partner) begin
        drive(1, 32'hAB, 0, '0);
        push_pair(0);
      end
      tick();
    end
    drive(0, '0, 0, '0);
    checks++;
    if (partner) begin
      if (bus.stutter_to !== 1'b0 || bus.stall_r !== 1'b0 || bus.src_cand_equiv !== 1'b1) begin
        failures++;
        $display("FAIL timeout_accept got to=%b sr=%b eq=%b want 0 0 1", bus.stutter_to, bus.stall_r, bus.src_cand_equiv);
      end
    end else begin
      if (bus.stutter_to !== 1'b1 || bus.src_cand_equiv !== 1'b0 || bus.stall_l !== 1'b1 || bus.stall_r !== 1'b1) begin
        failures++;
        $display("FAIL timeout_expire got to=%b eq=%b sl=%b sr=%b want 1 0 1 1",
                 bus.stutter_to, bus.src_cand_equiv, bus.stall_l, bus.stall_r);
      end
      drive(1, 32'h1, 1, 32'h1);
      tick();
      tick();
      drive(0, '0, 0, '0);
      checks++;
      if (bus.stutter_to !== 1'b1 || bus.pair_cnt !== 3'd0 || bus.proto_err !== 1'b0) begin
        failures++;
        $display("FAIL timeout_terminal got to=%b cnt=%0d pe=%b want 1 0 0", bus.stutter_to, bus.pair_cnt, bus.proto_err);
      end
    end
  endtask

  task automatic test_proto();
    do_reset();
    drive(1, 32'h10, 0, '0);
    tick();
    drive(1, 32'h55, 0, '0);
    tick();
    checks++;
    if (bus.proto_err !== 1'b1 || bus.src_cand_equiv !== 1'b0 || bus.stall_l !== 1'b1) begin
      failures++;
      $display("FAIL proto_set got pe=%b eq=%b sl=%b want 1 0 1", bus.proto_err, bus.src_cand_equiv, bus.stall_l);
    end
    model_equiv = 1'b0;
    drive(0, '0, 1, 32'h10);
    push_pair(0);
    tick();
    drive(0, '0, 0, '0);
    checks++;
    if (bus.stall_l !== 1'b0 || bus.proto_err !== 1'b1 || bus.stutter_to !== 1'b0) begin
      failures++;
      $display("FAIL proto_after got sl=%b pe=%b to=%b want 0 1 0", bus.stall_l, bus.proto_err, bus.stutter_to);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    drive(1, 32'h9, 1, 32'h9);
    push_pair(0);
    tick();
    drive(0, '0, 1, 32'h77);
    tick();
    drive(0, '0, 0, '0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_cnt   = '0;
    model_equiv = 1'b1;
    checks++;
    if (bus.stall_l !== 1'b0 || bus.stall_r !== 1'b0 || bus.pair_cnt !== 3'd0 ||
        bus.src_cand_equiv !== 1'b1 || bus.pair_vld !== 1'b0) begin
      failures++;
      $display("FAIL mid_wait_reset got sl=%b sr=%b cnt=%0d eq=%b pv=%b want 0 0 0 1 0",
               bus.stall_l, bus.stall_r, bus.pair_cnt, bus.src_cand_equiv, bus.pair_vld);
    end
    drive(1, 32'h5, 1, 32'h5);
    push_pair(0);
    tick();
    drive(0, '0, 0, '0);
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1, 32'hA0, 0, '0);
    tick();
    drive(0, '0, 1, 32'hA0);
    push_pair(0);
    tick();
    drive(0, '0, 1, 32'hB0);
    tick();
    checks++;
    if (bus.stall_r !== 1'b1 || bus.stall_l !== 1'b0) begin
      failures++;
      $display("FAIL b2b_swap got sl=%b sr=%b want 0 1", bus.stall_l, bus.stall_r);
    end
    drive(1, 32'hB1, 0, '0);
    push_pair(1);
    tick();
    drive(0, '0, 0, '0);
    checks++;
    if (bus.stall_l !== 1'b1 || bus.stall_r !== 1'b1 || bus.src_cand_equiv !== 1'b0) begin
      failures++;
      $display("FAIL b2b_wait_mismatch got sl=%b sr=%b eq=%b want 1 1 0", bus.stall_l, bus.stall_r, bus.src_cand_equiv);
    end
  endtask

  task automatic test_saturation();
    logic [OBS_W-1:0] v;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      v = $urandom;
      drive(1, v, 1, v);
      push_pair(0);
      tick();
    end
    drive(0, '0, 0, '0);
    tick();
    checks++;
    if (bus.pair_cnt !== 3'd7 || bus.src_cand_equiv !== 1'b1) begin
      failures++;
      $display("FAIL saturation got cnt=%0d eq=%b want 7 1", bus.pair_cnt, bus.src_cand_equiv);
    end
  endtask

  initial begin
    drive(0, '0, 0, '0);
    model_cnt   = '0;
    model_equiv = 1'b1;
    test_reset();
    test_lockstep();
    test_left_ahead();
    test_mismatch();
    test_timeout(1'b1);
    test_timeout(1'b0);
    test_proto();
    test_reset_mid_wait();
    test_back_to_back();
    test_saturation();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
